// File: rtl/clock_ctrl_pkg.sv
// Shared types for the clock mux switch sequencer: FSM states and abort codes.
// Pure declarations; no logic, no latency.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_NEW = 3'd1,
    DIS_OLD = 3'd2,
    EN_NEW  = 3'd3,
    REL_OLD = 3'd4,
    DONE    = 3'd5
  } sw_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_PARENT_TO = 2'd1,
    ERR_DIS_TO    = 2'd2,
    ERR_EN_TO     = 2'd3
  } sw_err_t;

endpackage

// File: rtl/clock_ack_sync.sv
// Multi-flop synchroniser for one asynchronous ack from the mux slice.
// Latency STAGES cycles; no backpressure, samples every cycle.
module clock_ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/clock_mux_switch_ctrl.sv
// Break-before-make sequencer for a two-input glitch-free clock mux slice.
// Outputs registered one cycle after each state move; sel_ready only while idle.
module clock_mux_switch_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       async_resetn,
  input  logic       sel_valid,
  input  logic       sel_target,
  output logic       sel_ready,
  output logic       parent0_request,
  input  logic       parent0_ready,
  output logic       parent1_request,
  input  logic       parent1_ready,
  output logic       async_enable0,
  output logic       async_enable1,
  input  logic       async_enable0_ack,
  input  logic       async_enable1_ack,
  output logic       active_valid,
  output logic       active_sel,
  output logic       switch_done,
  output logic       error,
  output logic [1:0] error_code,
  input  logic       error_clear
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  sw_state_t       r_state;
  sw_state_t       w_state_nxt;
  logic            r_tgt;
  logic            r_old;
  logic            r_had_old;
  logic [TO_W-1:0] r_to_cnt;
  logic [1:0]      r_req;
  logic [1:0]      r_en;
  logic            r_active_valid;
  logic            r_active_sel;
  logic            r_sel_ready;
  logic            r_error;
  sw_err_t         r_err_code;

  logic [1:0]      w_ack_sync;
  logic            w_accept;
  logic            w_timeout;
  logic            w_in_wait;
  logic            w_tgt_ready;
  logic            w_abort;

  clock_ack_sync #(.STAGES(SYNC_STAGES)) u_ack0_sync (
    .clock        (clock),
    .async_resetn (async_resetn),
    .i_async      (async_enable0_ack),
    .o_sync       (w_ack_sync[0])
  );

  clock_ack_sync #(.STAGES(SYNC_STAGES)) u_ack1_sync (
    .clock        (clock),
    .async_resetn (async_resetn),
    .i_async      (async_enable1_ack),
    .o_sync       (w_ack_sync[1])
  );

  assign w_accept    = sel_valid & r_sel_ready;
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_in_wait   = (r_state == REQ_NEW) || (r_state == DIS_OLD) || (r_state == EN_NEW);
  assign w_tgt_ready = r_tgt ? parent1_ready : parent0_ready;
  // A wait state leaving straight for DONE can only be a timeout abort.
  assign w_abort     = w_in_wait && (w_state_nxt == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (r_active_valid && (sel_target == r_active_sel)) w_state_nxt = DONE;
          else                                                 w_state_nxt = REQ_NEW;
        end
      end
      REQ_NEW: begin
        if (w_tgt_ready)    w_state_nxt = r_had_old ? DIS_OLD : EN_NEW;
        else if (w_timeout) w_state_nxt = DONE;
      end
      DIS_OLD: begin
        if (!w_ack_sync[r_old]) w_state_nxt = EN_NEW;
        else if (w_timeout)     w_state_nxt = DONE;
      end
      EN_NEW: begin
        if (w_ack_sync[r_tgt]) w_state_nxt = REL_OLD;
        else if (w_timeout)    w_state_nxt = DONE;
      end
      REL_OLD: w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_to_cnt  <= '0;
      r_tgt     <= 1'b0;
      r_old     <= 1'b0;
      r_had_old <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_to_cnt <= '0;
      else if (w_in_wait)         r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_accept) begin
        r_tgt     <= sel_target;
        r_old     <= r_active_sel;
        r_had_old <= r_active_valid;
      end
    end
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_req          <= 2'b00;
      r_en           <= 2'b00;
      r_active_valid <= 1'b0;
      r_active_sel   <= 1'b0;
      r_sel_ready    <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= ERR_NONE;
    end else begin
      r_sel_ready <= (w_state_nxt == IDLE);
      // Clear first so an abort in the same cycle re-arms with its own code.
      if (error_clear) begin
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      case (r_state)
        REQ_NEW: begin
          if (w_abort) begin
            r_req[r_tgt] <= 1'b0;
            r_error      <= 1'b1;
            r_err_code   <= ERR_PARENT_TO;
          end else begin
            r_req[r_tgt] <= 1'b1;
          end
        end
        DIS_OLD: begin
          if (w_abort) begin
            r_en[r_old]  <= 1'b1;
            r_req[r_tgt] <= 1'b0;
            r_error      <= 1'b1;
            r_err_code   <= ERR_DIS_TO;
          end else begin
            r_en[r_old]  <= 1'b0;
          end
        end
        EN_NEW: begin
          if (w_abort) begin
            r_en[r_tgt]    <= 1'b0;
            r_req[r_tgt]   <= 1'b0;
            if (r_had_old) r_req[r_old] <= 1'b0;
            r_active_valid <= 1'b0;
            r_error        <= 1'b1;
            r_err_code     <= ERR_EN_TO;
          end else begin
            r_en[r_tgt]    <= 1'b1;
            r_en[~r_tgt]   <= 1'b0;
          end
        end
        REL_OLD: begin
          if (r_had_old) r_req[r_old] <= 1'b0;
          r_active_sel   <= r_tgt;
          r_active_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The slice must never see both inputs enabled at once.
  a_no_overlap: assert property (@(posedge clock) disable iff (!async_resetn)
                                 !(r_en[0] && r_en[1]));

  assign sel_ready       = r_sel_ready;
  assign parent0_request = r_req[0];
  assign parent1_request = r_req[1];
  assign async_enable0   = r_en[0];
  assign async_enable1   = r_en[1];
  assign active_valid    = r_active_valid;
  assign active_sel      = r_active_sel;
  assign switch_done     = (r_state == DONE);
  assign error           = r_error;
  assign error_code      = r_err_code;

endmodule

// File: tb/tb_clock_mux_switch_ctrl.sv
// Directed bench for clock_mux_switch_ctrl: switch, no-op, timeouts, reset mid-switch.
module tb_clock_mux_switch_ctrl;

  logic       clock = 1'b0;
  logic       async_resetn;
  logic       sel_valid, sel_target, sel_ready;
  logic       parent0_request, parent0_ready, parent1_request, parent1_ready;
  logic       async_enable0, async_enable1, async_enable0_ack, async_enable1_ack;
  logic       active_valid, active_sel, switch_done, error, error_clear;
  logic [1:0] error_code;
  logic       stuck0, stuck1;

  int errors = 0;
  int checks = 0;
  int overlaps = 0;
  int cyc;

  always #5 clock = ~clock;

  assign async_enable0_ack = async_enable0 & ~stuck0;
  assign async_enable1_ack = async_enable1 & ~stuck1;

  clock_mux_switch_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clock             (clock),
    .async_resetn      (async_resetn),
    .sel_valid         (sel_valid),
    .sel_target        (sel_target),
    .sel_ready         (sel_ready),
    .parent0_request   (parent0_request),
    .parent0_ready     (parent0_ready),
    .parent1_request   (parent1_request),
    .parent1_ready     (parent1_ready),
    .async_enable0     (async_enable0),
    .async_enable1     (async_enable1),
    .async_enable0_ack (async_enable0_ack),
    .async_enable1_ack (async_enable1_ack),
    .active_valid      (active_valid),
    .active_sel        (active_sel),
    .switch_done       (switch_done),
    .error             (error),
    .error_code        (error_code),
    .error_clear       (error_clear)
  );

  always @(posedge clock) if (async_enable0 && async_enable1) overlaps++;

  function automatic logic [15:0] all_outs();
    return 16'({parent0_request, parent1_request, async_enable0, async_enable1,
                active_valid, active_sel, switch_done, error, error_code, sel_ready});
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic t);
    int w;
    sel_valid  = 1'b1;
    sel_target = t;
    w = 0;
    while (sel_ready !== 1'b1 && w < 20) begin step(1); w++; end
    check("send_ready_seen", 16'(w < 20), 16'd1);
    step(1);
    sel_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (switch_done !== 1'b1 && n < budget) begin step(1); n++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    async_resetn  = 1'b0;
    sel_valid     = 1'b0;
    sel_target    = 1'b0;
    parent0_ready = 1'b0;
    parent1_ready = 1'b0;
    error_clear   = 1'b0;
    stuck0        = 1'b0;
    stuck1        = 1'b0;
    #12;
    check("reset_outputs", all_outs(), 16'd0);
    #11 async_resetn = 1'b1;
    step(1);
    check("ready_after_reset", 16'(sel_ready), 16'd1);

    // First switch to source 0 from nothing enabled.
    send(1'b0);
    step(1);
    check("t1_p0_req", 16'(parent0_request), 16'd1);
    check("t1_en0_not_yet", 16'(async_enable0), 16'd0);
    check("t1_busy_not_ready", 16'(sel_ready), 16'd0);
    step(2);
    parent0_ready = 1'b1;
    wait_done(30, cyc);
    check("t1_done_in_budget", 16'(cyc < 30), 16'd1);
    check("t1_active_valid", 16'(active_valid), 16'd1);
    check("t1_active_sel", 16'(active_sel), 16'd0);
    check("t1_en0", 16'(async_enable0), 16'd1);
    check("t1_en1", 16'(async_enable1), 16'd0);
    check("t1_no_error", 16'({error, error_code}), 16'd0);

    // Switch 0 -> 1, break before make.
    send(1'b1);
    step(1);
    check("t2_p1_req", 16'(parent1_request), 16'd1);
    check("t2_en0_still", 16'(async_enable0), 16'd1);
    parent1_ready = 1'b1;
    step(2);
    check("t2_en0_dropped", 16'(async_enable0), 16'd0);
    check("t2_en1_not_yet", 16'(async_enable1), 16'd0);
    wait_done(30, cyc);
    check("t2_done_in_budget", 16'(cyc < 30), 16'd1);
    check("t2_active_sel", 16'(active_sel), 16'd1);
    check("t2_active_valid", 16'(active_valid), 16'd1);
    check("t2_p0_released", 16'(parent0_request), 16'd0);
    check("t2_p1_held", 16'(parent1_request), 16'd1);
    check("t2_enables", 16'({async_enable0, async_enable1}), 16'b01);

    // Same target: immediate completion, nothing moves.
    step(1);
    send(1'b1);
    check("t3_done_immediate", 16'(switch_done), 16'd1);
    check("t3_outputs_kept", 16'({parent0_request, parent1_request, async_enable0, async_enable1}),
          16'b0101);
    step(1);
    check("t3_done_pulse_once", 16'(switch_done), 16'd0);

    // Back to source 0, then parent1 never becomes ready.
    send(1'b0);
    wait_done(30, cyc);
    check("t4_restore_sel", 16'({active_valid, active_sel}), 16'b10);
    step(1);
    parent1_ready = 1'b0;
    send(1'b1);
    wait_done(40, cyc);
    check("t4_timeout_cycles", 16'(cyc), 16'd16);
    check("t4_p1_req_dropped", 16'(parent1_request), 16'd0);
    check("t4_error", 16'(error), 16'd1);
    check("t4_code", 16'(error_code), 16'd1);
    check("t4_en0_kept", 16'({async_enable0, async_enable1}), 16'b10);
    check("t4_active_kept", 16'({active_valid, active_sel}), 16'b10);
    check("t4_p0_kept", 16'(parent0_request), 16'd1);

    // Ack1 stuck low: enable-ack timeout tears everything down.
    step(1);
    parent1_ready = 1'b1;
    stuck1 = 1'b1;
    send(1'b1);
    wait_done(60, cyc);
    check("t5_done_in_budget", 16'(cyc < 60), 16'd1);
    check("t5_code", 16'(error_code), 16'd3);
    check("t5_error", 16'(error), 16'd1);
    check("t5_enables_off", 16'({async_enable0, async_enable1}), 16'b00);
    check("t5_requests_off", 16'({parent0_request, parent1_request}), 16'b00);
    check("t5_active_valid", 16'(active_valid), 16'd0);
    error_clear = 1'b1;
    step(1);
    error_clear = 1'b0;
    check("t5_error_cleared", 16'({error, error_code}), 16'd0);

    // Reset while sitting in EN_NEW with enable1 driven.
    step(1);
    send(1'b1);
    step(4);
    check("t6_en1_driven", 16'(async_enable1), 16'd1);
    check("t6_busy", 16'(sel_ready), 16'd0);
    async_resetn = 1'b0;
    #1;
    check("t6_async_reset_outputs", all_outs(), 16'd0);
    step(1);
    async_resetn = 1'b1;
    stuck1 = 1'b0;
    step(2);
    check("t6_ready_after", 16'(sel_ready), 16'd1);
    check("t6_active_after", 16'(active_valid), 16'd0);

    check("no_enable_overlap", 16'(overlaps), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
